// File: rtl/irq_c0_nest_pkg.sv
// Shared definitions for the nested interrupt C0 block: op encodings and
// width helpers so the interface, encoder and top agree on field sizes.
package irq_pkg;

    localparam int IRQ_OP_NBIT = 2;

    typedef enum logic [IRQ_OP_NBIT-1:0] {
        IRQ_OP_NOP   = 2'd0,
        IRQ_OP_ENTER = 2'd1,
        IRQ_OP_ERET  = 2'd2,
        IRQ_OP_RSVD  = 2'd3
    } irq_op_e;

    function automatic int inum_width(input int nirq);
        return (nirq > 1) ? $clog2(nirq) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/irq_c0_nest_if.sv
// ID-stage facing bundle of the interrupt block: op/CSR commit inputs and the
// combinational status the decoder reads.
interface irq_c0_nest_if
    import irq_pkg::*;
#(
    parameter int NIRQ  = 8,
    parameter int DEPTH = 4,
    parameter int W     = 32
) ();

    localparam int IW = inum_width(NIRQ);
    localparam int LW = level_width(DEPTH);

    logic                   en;
    logic [NIRQ-1:0]        irq_src;
    logic [IRQ_OP_NBIT-1:0] op;
    logic [W-1:0]           enter_pc;
    logic                   ie_we;
    logic                   ie_w;
    logic                   epc_we;
    logic [W-1:0]           epc_w;
    logic                   mask_we;
    logic [NIRQ-1:0]        mask_w;

    logic                   ie;
    logic [NIRQ-1:0]        mask;
    logic [NIRQ-1:0]        pending;
    logic [W-1:0]           epc;
    logic                   ivld;
    logic [IW-1:0]          inum;
    logic [LW-1:0]          level;
    logic                   err;

    modport master (
        output en, irq_src, op, enter_pc, ie_we, ie_w, epc_we, epc_w, mask_we, mask_w,
        input  ie, mask, pending, epc, ivld, inum, level, err
    );

    modport slave (
        input  en, irq_src, op, enter_pc, ie_we, ie_w, epc_we, epc_w, mask_we, mask_w,
        output ie, mask, pending, epc, ivld, inum, level, err
    );

endinterface

// File: rtl/irq_c0_nest_prio_enc.sv
// Fixed-priority encoder (index 0 wins) that only admits requests whose index
// is strictly below an optional threshold.
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NIRQ = 8,
    parameter int IW   = inum_width(NIRQ)
) (
    input  logic [NIRQ-1:0] req,
    input  logic [IW-1:0]   thr,
    input  logic            thr_vld,
    output logic            vld,
    output logic [IW-1:0]   idx
);

    // Scan from the lowest priority upward so the last hit is the lowest index.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i] && (!thr_vld || (IW'(i) < thr))) begin
                vld = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_c0_nest.sv
// Nested interrupt C0 block: edge-latched requests, mask/global enable,
// fixed-priority arbitration and an EPC/priority stack for nesting.
module irq_c0_nest
    import irq_pkg::*;
#(
    parameter int NIRQ  = 8,
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    irq_c0_nest_if.slave  bus
);

    localparam int IW = inum_width(NIRQ);
    localparam int LW = level_width(DEPTH);

    logic            ie_q, ie_d;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] prev_q, prev_d;
    logic [LW-1:0]   level_q, level_d;
    logic            err_q, err_d;
    logic [W-1:0]    stk_epc_q [DEPTH];
    logic [W-1:0]    stk_epc_d [DEPTH];
    logic [IW-1:0]   stk_num_q [DEPTH];
    logic [IW-1:0]   stk_num_d [DEPTH];

    logic [W-1:0]    top_epc;
    logic [IW-1:0]   top_num;
    logic            enc_vld;
    logic [IW-1:0]   enc_idx;
    logic            ivld;
    logic [IW-1:0]   inum;
    logic            is_enter, is_eret;
    logic            do_enter, do_eret;
    logic            csr_epc_ok;

    // Top-of-stack view; reads as zero while the stack is empty.
    always_comb begin
        top_epc = '0;
        top_num = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (level_q == LW'(i + 1)) begin
                top_epc = stk_epc_q[i];
                top_num = stk_num_q[i];
            end
        end
    end

    irq_prio_enc #(.NIRQ(NIRQ), .IW(IW)) u_prio_enc (
        .req     (pending_q & mask_q),
        .thr     (top_num),
        .thr_vld (level_q != '0),
        .vld     (enc_vld),
        .idx     (enc_idx)
    );

    assign ivld = ie_q && enc_vld && (level_q < LW'(DEPTH));
    assign inum = ivld ? enc_idx : '0;

    assign is_enter   = bus.en && (bus.op == IRQ_OP_ENTER);
    assign is_eret    = bus.en && (bus.op == IRQ_OP_ERET);
    assign do_enter   = is_enter && ivld;
    assign do_eret    = is_eret && (level_q != '0);
    assign csr_epc_ok = bus.en && bus.epc_we && !do_enter && !do_eret;

    // Op effects are applied after CSR writes so the op's ie value dominates,
    // and fresh edges are OR'd in last so a same-cycle request is never lost.
    always_comb begin
        prev_d    = bus.irq_src;
        pending_d = pending_q;
        ie_d      = ie_q;
        mask_d    = mask_q;
        level_d   = level_q;
        err_d     = err_q;
        stk_epc_d = stk_epc_q;
        stk_num_d = stk_num_q;

        if (bus.en && bus.ie_we)   ie_d   = bus.ie_w;
        if (bus.en && bus.mask_we) mask_d = bus.mask_w;

        for (int i = 0; i < DEPTH; i++) begin
            if (do_enter && (level_q == LW'(i))) begin
                stk_epc_d[i] = bus.enter_pc;
                stk_num_d[i] = inum;
            end else if (csr_epc_ok && (level_q == LW'(i + 1))) begin
                stk_epc_d[i] = bus.epc_w;
            end
        end

        if (do_enter) begin
            pending_d[inum] = 1'b0;
            ie_d            = 1'b0;
            level_d         = level_q + 1'b1;
        end
        if (do_eret) begin
            ie_d    = 1'b1;
            level_d = level_q - 1'b1;
        end
        if ((is_enter && !ivld) || (is_eret && (level_q == '0))) err_d = 1'b1;

        pending_d = pending_d | (bus.irq_src & ~prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q      <= 1'b0;
            mask_q    <= '0;
            pending_q <= '0;
            prev_q    <= '0;
            level_q   <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_epc_q[i] <= '0;
                stk_num_q[i] <= '0;
            end
        end else begin
            ie_q      <= ie_d;
            mask_q    <= mask_d;
            pending_q <= pending_d;
            prev_q    <= prev_d;
            level_q   <= level_d;
            err_q     <= err_d;
            stk_epc_q <= stk_epc_d;
            stk_num_q <= stk_num_d;
        end
    end

    assign bus.ie      = ie_q;
    assign bus.mask    = mask_q;
    assign bus.pending = pending_q;
    assign bus.epc     = top_epc;
    assign bus.ivld    = ivld;
    assign bus.inum    = inum;
    assign bus.level   = level_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_irq_c0_nest.sv
// Directed bench for irq_c0_nest: walks request latency, nesting, stack full,
// stalls, collisions, masking, EPC writes and reset mid-nest.
module tb_irq_c0_nest;
    import irq_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    irq_c0_nest_if #(.NIRQ(8), .DEPTH(4), .W(32)) bus ();

    irq_c0_nest #(.NIRQ(8), .DEPTH(4), .W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One committed op, then back to NOP.
    task automatic applyStimulus(input logic [1:0] op_v, input logic [31:0] pc_v);
        bus.op       = op_v;
        bus.enter_pc = pc_v;
        tick(1);
        bus.op       = IRQ_OP_NOP;
        bus.enter_pc = '0;
    endtask

    task automatic pulseIrq(input logic [7:0] src, input logic set_ie);
        bus.irq_src = src;
        bus.ie_we   = set_ie;
        bus.ie_w    = 1'b1;
        tick(1);
        bus.irq_src = '0;
        bus.ie_we   = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.en = 1'b1;     bus.irq_src = '0;  bus.op = IRQ_OP_NOP; bus.enter_pc = '0;
        bus.ie_we = 1'b0;  bus.ie_w = 1'b0;   bus.epc_we = 1'b0;   bus.epc_w = '0;
        bus.mask_we = 1'b0; bus.mask_w = '0;
        tick(2);
        rst = 1'b0;

        checkOutput("rst_ie",      32'(bus.ie),      32'h0);
        checkOutput("rst_mask",    32'(bus.mask),    32'h0);
        checkOutput("rst_pending", 32'(bus.pending), 32'h0);
        checkOutput("rst_epc",     bus.epc,          32'h0);
        checkOutput("rst_ivld",    32'(bus.ivld),    32'h0);
        checkOutput("rst_level",   32'(bus.level),   32'h0);
        checkOutput("rst_err",     32'(bus.err),     32'h0);

        bus.mask_we = 1'b1; bus.mask_w = 8'hFF;
        pulseIrq(8'h08, 1'b1);
        bus.mask_we = 1'b0;
        checkOutput("lat_pending", 32'(bus.pending), 32'h08);
        checkOutput("lat_ivld",    32'(bus.ivld),    32'h1);
        checkOutput("lat_inum",    32'(bus.inum),    32'h3);

        applyStimulus(IRQ_OP_ENTER, 32'h100);
        checkOutput("e1_level", 32'(bus.level), 32'h1);
        checkOutput("e1_epc",   bus.epc,        32'h100);
        checkOutput("e1_ie",    32'(bus.ie),    32'h0);
        checkOutput("e1_pend",  32'(bus.pending), 32'h0);
        pulseIrq(8'h22, 1'b1);
        checkOutput("thr_ivld", 32'(bus.ivld), 32'h1);
        checkOutput("thr_inum", 32'(bus.inum), 32'h1);
        applyStimulus(IRQ_OP_ENTER, 32'h200);
        checkOutput("e2_level", 32'(bus.level),   32'h2);
        checkOutput("e2_epc",   bus.epc,          32'h200);
        checkOutput("e2_pend",  32'(bus.pending), 32'h20);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        checkOutput("r1_epc",  bus.epc,       32'h100);
        checkOutput("r1_ie",   32'(bus.ie),   32'h1);
        checkOutput("r1_ivld", 32'(bus.ivld), 32'h0);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        checkOutput("r0_epc",  bus.epc,       32'h0);
        checkOutput("r0_ivld", 32'(bus.ivld), 32'h1);
        checkOutput("r0_inum", 32'(bus.inum), 32'h5);
        applyStimulus(IRQ_OP_ENTER, 32'h300);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        checkOutput("clr_pend", 32'(bus.pending), 32'h0);

        // Nest four deep, each level preempting the one below.
        pulseIrq(8'h80, 1'b0);
        checkOutput("f7_inum", 32'(bus.inum), 32'h7);
        applyStimulus(IRQ_OP_ENTER, 32'h1000);
        pulseIrq(8'h40, 1'b1);
        applyStimulus(IRQ_OP_ENTER, 32'h1001);
        pulseIrq(8'h20, 1'b1);
        applyStimulus(IRQ_OP_ENTER, 32'h1002);
        pulseIrq(8'h10, 1'b1);
        checkOutput("f4_inum", 32'(bus.inum), 32'h4);
        applyStimulus(IRQ_OP_ENTER, 32'h1003);
        pulseIrq(8'h01, 1'b1);
        checkOutput("full_level", 32'(bus.level),   32'h4);
        checkOutput("full_ivld",  32'(bus.ivld),    32'h0);
        checkOutput("full_pend",  32'(bus.pending), 32'h01);
        checkOutput("full_epc",   bus.epc,          32'h1003);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        checkOutput("unf_level", 32'(bus.level), 32'h3);
        checkOutput("unf_epc",   bus.epc,        32'h1002);
        checkOutput("unf_ivld",  32'(bus.ivld),  32'h1);
        checkOutput("unf_inum",  32'(bus.inum),  32'h0);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        checkOutput("unw_level", 32'(bus.level), 32'h0);
        applyStimulus(IRQ_OP_ENTER, 32'h2000);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        checkOutput("unw_pend", 32'(bus.pending), 32'h0);
        checkOutput("unw_err",  32'(bus.err),     32'h0);

        // Stall: requests still latch, ops are dropped without error.
        bus.en = 1'b0;
        pulseIrq(8'h04, 1'b0);
        bus.op = IRQ_OP_ENTER;
        tick(2);
        bus.op = IRQ_OP_NOP;
        bus.en = 1'b1;
        checkOutput("stall_pend",  32'(bus.pending), 32'h04);
        checkOutput("stall_level", 32'(bus.level),   32'h0);
        checkOutput("stall_err",   32'(bus.err),     32'h0);
        checkOutput("stall_inum",  32'(bus.inum),    32'h2);

        bus.irq_src = 8'h04;
        applyStimulus(IRQ_OP_ENTER, 32'h3000);
        bus.irq_src = '0;
        checkOutput("col_pend",  32'(bus.pending), 32'h04);
        checkOutput("col_level", 32'(bus.level),   32'h1);
        checkOutput("col_epc",   bus.epc,          32'h3000);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        checkOutput("eret0_err",   32'(bus.err),   32'h1);
        checkOutput("eret0_level", 32'(bus.level), 32'h0);
        tick(3);
        checkOutput("err_sticky", 32'(bus.err), 32'h1);

        applyStimulus(IRQ_OP_ENTER, 32'h4000);
        applyStimulus(IRQ_OP_ERET, 32'h0);
        bus.mask_we = 1'b1; bus.mask_w = 8'hFE;
        pulseIrq(8'h01, 1'b0);
        bus.mask_we = 1'b0;
        checkOutput("msk_ivld", 32'(bus.ivld),    32'h0);
        checkOutput("msk_pend", 32'(bus.pending), 32'h01);
        bus.mask_we = 1'b1; bus.mask_w = 8'hFF;
        tick(1);
        bus.mask_we = 1'b0;
        checkOutput("unmsk_ivld", 32'(bus.ivld), 32'h1);
        checkOutput("unmsk_inum", 32'(bus.inum), 32'h0);

        // EPC CSR writes: applied at level 1, discarded on ERET, ignored when empty.
        bus.epc_we = 1'b1; bus.epc_w = 32'h999;
        applyStimulus(IRQ_OP_ENTER, 32'h5000);
        checkOutput("epc_enter_wins", bus.epc, 32'h5000);
        bus.epc_w = 32'hABC;
        tick(1);
        checkOutput("epc_write", bus.epc, 32'hABC);
        bus.epc_w = 32'h777;
        applyStimulus(IRQ_OP_ERET, 32'h0);
        checkOutput("epc_eret_level", 32'(bus.level), 32'h0);
        tick(1);
        bus.epc_we = 1'b0;
        checkOutput("epc_empty", bus.epc, 32'h0);

        // Reset mid-nest clears everything, including the sticky error.
        pulseIrq(8'h02, 1'b0);
        applyStimulus(IRQ_OP_ENTER, 32'h6000);
        checkOutput("mid_level", 32'(bus.level), 32'h1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checkOutput("rst2_level", 32'(bus.level),   32'h0);
        checkOutput("rst2_epc",   bus.epc,          32'h0);
        checkOutput("rst2_err",   32'(bus.err),     32'h0);
        checkOutput("rst2_mask",  32'(bus.mask),    32'h0);
        checkOutput("rst2_ie",    32'(bus.ie),      32'h0);

        applyStimulus(IRQ_OP_ENTER, 32'h7000);
        checkOutput("enter_noivld_err",   32'(bus.err),   32'h1);
        checkOutput("enter_noivld_level", 32'(bus.level), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
